// File: rtl/seq_mul_acc_if.sv
// Request/response bundle for the sequential multiply-accumulate unit.
//   master: drives start_strb_i, a_i, b_i, acc_i; observes done_strb_o, busy_o, out_o
//   slave : the multiply-accumulate responder
interface seq_mul_acc_if #(
  parameter int unsigned N = 41
) ();
  localparam int unsigned W = 2 * N;

  logic         start_strb_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] acc_i;
  logic         done_strb_o;
  logic         busy_o;
  logic [W-1:0] out_o;

  modport master (
    output start_strb_i, a_i, b_i, acc_i,
    input  done_strb_o, busy_o, out_o
  );

  modport slave (
    input  start_strb_i, a_i, b_i, acc_i,
    output done_strb_o, busy_o, out_o
  );
endinterface

// File: rtl/seq_mul_acc.sv
// Sequential shift-add multiply-accumulate: out = acc + a*b (mod 2^(2N)).
// One partial-product step every CLK_DIV clocks, 2N steps, fixed latency.
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : seq_mul_acc_if.slave
//            start_strb_i/a_i/b_i/acc_i in, done_strb_o/busy_o/out_o out
module seq_mul_acc #(
  parameter int unsigned N       = 41,
  parameter int unsigned CLK_DIV = 50
) (
  input  logic          clk_i,
  input  logic          rst_i,
  seq_mul_acc_if.slave  bus
);
  localparam int unsigned W      = 2 * N;
  localparam int unsigned STEP_W = $clog2(W + 1);
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [W-1:0]        mcand;
  logic [W-1:0]        mplier;
  logic [W-1:0]        partial;
  logic [STEP_W-1:0]   step_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                done_q;
  logic                busy_q;
  logic [W-1:0]        out_q;

  logic [W-1:0]        step_sum_c;
  logic                step_en_c;
  logic                last_step_c;

  // Partial sum after the current step; unsigned add is exact modulo 2^W.
  assign step_sum_c  = mplier[0] ? W'(partial + mcand) : partial;
  assign step_en_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_step_c = (step_cnt == STEP_W'(W - 1));

  // Control FSM and datapath; done/out are set on the edge of the final step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      partial  <= '0;
      step_cnt <= '0;
      div_cnt  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_strb_i) begin
            mcand    <= bus.a_i;
            mplier   <= bus.b_i;
            partial  <= bus.acc_i;
            step_cnt <= '0;
            div_cnt  <= '0;
            busy_q   <= 1'b1;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          if (step_en_c) begin
            div_cnt  <= '0;
            partial  <= step_sum_c;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            step_cnt <= STEP_W'(step_cnt + STEP_W'(1));
            if (last_step_c) begin
              out_q  <= step_sum_c;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_DONE;
            end
          end else begin
            div_cnt <= DIV_W'(div_cnt + DIV_W'(1));
          end
        end

        // Single-cycle completion; a start seen here is dropped.
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done_strb_o = done_q;
  assign bus.busy_o      = busy_q;
  assign bus.out_o       = out_q;
endmodule

// File: doc/seq_mul_acc.md
Name: seq_mul_acc

Overview:
- Sequential shift-add multiply-accumulate responder. It computes out = acc + a*b on request from a controller such as the PID core.
- Handshake is a one-cycle start strobe in and a one-cycle done strobe out.
- Trades latency for area: one partial-product step every CLK_DIV clocks.
- Holds its result stable so the initiator can feed it back as the next accumulator input.

Parameters:
- N, 41, base operand width. All datapath ports are 2N bits wide, two's complement.
- CLK_DIV, 50, clocks per shift-add step. Legal range is 1 or more; 1 means one step per clock.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_strb_i  in  1  one-cycle request; operands are sampled in this cycle
- a_i  in  2N  signed multiplicand
- b_i  in  2N  signed multiplier
- acc_i  in  2N  signed accumulator addend
- done_strb_o  out  1  one-cycle pulse; out_o is valid from this cycle
- busy_o  out  1  high while a request is in progress (RUN state)
- out_o  out  2N  signed result, held until the next completion

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values: state=IDLE, done_strb_o=0, busy_o=0, out_o=0; internal operand, step and divider registers cleared.
- Reset is honoured in any state, including mid-RUN. The operation is abandoned and no done_strb_o is produced.
- Arithmetic:
  - Result = acc_i + a_i*b_i, truncated modulo 2^(2N) (low 2N bits).
  - The low 2N bits of a two's-complement product equal those of the unsigned product, so plain unsigned shift-add over 2N steps is exact.
  - No saturation and no overflow flag; wrap-around is required behaviour.
- FSM:
  - IDLE: if start_strb_i=1, latch a_i into the multiplicand register, b_i into the multiplier shift register and acc_i into the partial-sum register. Clear step_cnt and div_cnt, then go to RUN. Otherwise stay in IDLE.
  - RUN: busy_o=1. div_cnt counts 0..CLK_DIV-1. On div_cnt==CLK_DIV-1, do one step:
    - if the multiplier LSB is 1, partial += multiplicand (mod 2^2N);
    - multiplicand <<= 1; multiplier >>= 1 (logical);
    - step_cnt += 1.
  - After step 2N completes, go to DONE.
  - DONE (exactly one cycle): out_o <= partial, done_strb_o=1, busy_o=0. Then go to IDLE.
- Latency: a start sampled at edge t gives done_strb_o high during cycle t + 2N*CLK_DIV + 1. The same edge updates out_o. Latency is fixed and independent of the operand values (no early exit).
- out_o changes only on entry to DONE or on reset. It is held through later RUN phases so the initiator may route it back into acc_i.
- Simultaneous and boundary events:
  - start_strb_i in RUN or DONE is ignored: no queueing, no error, latched operands unaffected.
  - start_strb_i in the cycle immediately after done_strb_o (state IDLE) is accepted. Back-to-back chaining is therefore possible with one idle-cycle gap.
  - Input changes on a_i, b_i or acc_i outside the start cycle have no effect.
  - rst_i and start_strb_i together: reset wins and the state stays IDLE.
  - a_i=0 or b_i=0 gives out_o=acc_i with the same fixed latency.
- done_strb_o is never high for two consecutive cycles.
- busy_o and done_strb_o are never high together.

Test Plan (N=4 so ports are 8 bits; CLK_DIV=2; expected latency 17):
- a=3, b=5, acc=0, start at t -> done_strb_o at t+17; out_o=8'h0F; busy_o high t+1..t+16.
- a=-3 (8'hFD), b=7, acc=10 -> out_o=8'hF5 (-11); out_o at 0 until the done cycle.
- Wrap: a=127, b=127, acc=0 -> out_o=8'h01 (16129 mod 256). Also a=-128, b=-1, acc=0 -> out_o=8'h80.
- Second start_strb_i at t+5 and again in the done cycle, with different operands -> both ignored; exactly one done pulse; result from the first operands only.
- Reset mid-run: start a=3, b=5; rst_i high at t+6 -> out_o=0, busy_o=0, no done pulse. A new start (a=2, b=2, acc=1) gives out_o=8'h05 17 cycles later.
- Chain: a=2, b=3, acc=0 gives out_o=6. Start the next request the cycle after done with a=4, b=5, acc_i=out_o -> out_o=8'h1A (26). With CLK_DIV=1 the same chain completes in 9 cycles per operation.
